// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: countdown, timed play with LFSR mole pick and scoring, game-over hold.
// Optional build macro MISS_PENALTY_EN: in PLAY a press with no matching hit costs one point (floor 0).
//
// state | meaning
// IDLE  | waiting for start, everything cleared
// COUNT | pre-game countdown, sec_left counts COUNTDOWN_SEC..1
// PLAY  | round running, moles raised/scored, sec_left counts ROUND_SEC..1
// DONE  | game over, score held, restart on start
module mole_round_ctrl #(
   parameter int NUM_MOLES     = 8,
   parameter int COUNTDOWN_SEC = 5,
   parameter int ROUND_SEC     = 30,
   parameter int TICKS_PER_SEC = 4,
   parameter int MOLE_UP_TICKS = 4,
   parameter int SCORE_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] hit_btn,
   output logic [NUM_MOLES-1:0] mole_en,
   output logic [7:0]           sec_left,
   output logic [1:0]           state,
   output logic [SCORE_W-1:0]   score,
   output logic                 game_over
);

   localparam int IDX_W = $clog2(NUM_MOLES);
   localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int TMR_W = $clog2(MOLE_UP_TICKS + 1);
   localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [NUM_MOLES-1:0] MOLE_ONE = NUM_MOLES'(1);
   localparam logic [SCORE_W-1:0]   SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [SUB_W-1:0]     sub_q, sub_d;
   logic [7:0]           sec_q, sec_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [NUM_MOLES-1:0] mole_q, mole_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [IDX_W-1:0]     prev_q, prev_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 game_over_q, game_over_d;

   logic                 lfsr_fb;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     pick_idx;
   logic [NUM_MOLES-1:0] pick_mole;
   logic                 sub_wrap;
   logic                 last_sec;
   logic                 hit_match;

   // Fibonacci taps 16,14,13,11 on a left-shifting register
   assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign cand      = lfsr_q[IDX_W-1:0];
   assign pick_idx  = (cand == prev_q) ? cand + IDX_W'(1) : cand;
   assign pick_mole = MOLE_ONE << pick_idx;
   assign sub_wrap  = tick && (sub_q == SUB_LAST);
   assign last_sec  = sub_wrap && (sec_q == 8'd1);
   assign hit_match = |(hit_btn & mole_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sub_q       <= '0;
         sec_q       <= '0;
         score_q     <= '0;
         mole_q      <= '0;
         tmr_q       <= '0;
         prev_q      <= '0;
         lfsr_q      <= 16'hACE1;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         sec_q       <= sec_d;
         score_q     <= score_d;
         mole_q      <= mole_d;
         tmr_q       <= tmr_d;
         prev_q      <= prev_d;
         lfsr_q      <= lfsr_d;
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      sec_d   = sec_q;
      score_d = score_q;
      mole_d  = mole_q;
      tmr_d   = tmr_q;
      prev_d  = prev_q;
      lfsr_d  = {lfsr_q[14:0], lfsr_fb};

      // shared seconds countdown for COUNT and PLAY; the last-second wrap is handled per state
      if ((state_q == S_COUNT || state_q == S_PLAY) && tick) begin
         sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
         if (sub_wrap && !last_sec)
            sec_d = sec_q - 8'd1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            mole_d = '0;
            if (start) begin
               state_d = S_COUNT;
               sec_d   = 8'(COUNTDOWN_SEC);
               sub_d   = '0;
            end
         end
         S_COUNT: begin
            if (last_sec) begin
               state_d = S_PLAY;
               sec_d   = 8'(ROUND_SEC);
               score_d = '0;
               mole_d  = pick_mole;
               prev_d  = pick_idx;
               tmr_d   = TMR_W'(MOLE_UP_TICKS);
            end
         end
         S_PLAY: begin
            if (hit_match) begin
               if (score_q != SCORE_MAX)
                  score_d = score_q + SCORE_W'(1);
               mole_d = '0;
            end else begin
`ifdef MISS_PENALTY_EN
               if ((|hit_btn) && (score_q != '0))
                  score_d = score_q - SCORE_W'(1);
`endif
               if (tick) begin
                  if (mole_q != '0) begin
                     tmr_d = tmr_q - TMR_W'(1);
                     if (tmr_q == TMR_W'(1))
                        mole_d = '0;
                  end else begin
                     mole_d = pick_mole;
                     prev_d = pick_idx;
                     tmr_d  = TMR_W'(MOLE_UP_TICKS);
                  end
               end
            end
            if (last_sec) begin
               state_d = S_DONE;
               sec_d   = '0;
               mole_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      game_over_d = (state_d == S_DONE);
   end

   assign mole_en   = mole_q;
   assign sec_left  = sec_q;
   assign state     = state_q;
   assign score     = score_q;
   assign game_over = game_over_q;

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round controller for the whack-a-mole game. Sequences a 5-second pre-game countdown, a timed play round and a game-over hold. During play it schedules which mole is raised, using a free-running LFSR, and scores debounced button hits. It sits between the slow-tick generator, the button debouncers and the LED/seven-segment drivers.

## Interface
Parameters:
- NUM_MOLES, 8: number of holes; must be a power of two, 2..16.
- COUNTDOWN_SEC, 5: pre-game countdown length in seconds.
- ROUND_SEC, 30: play-round length in seconds.
- TICKS_PER_SEC, 4: tick pulses per second.
- MOLE_UP_TICKS, 4: ticks a mole stays raised if not hit.
- SCORE_W, 8: score width.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-low reset.
- tick, in, 1: one-cycle enable pulse, TICKS_PER_SEC per second.
- start, in, 1: one-cycle start pulse.
- hit_btn, in, NUM_MOLES: debounced one-cycle pulses, one bit per hole.
- mole_en, out, NUM_MOLES: one-hot raised mole, or all zero.
- sec_left, out, 8: seconds remaining in the current phase.
- state, out, 2: current state; IDLE=0, COUNT=1, PLAY=2, DONE=3.
- score, out, SCORE_W: current score.
- game_over, out, 1: high in DONE.

## Operation
- All outputs are registered. Reset (reset==0 at a clk edge) gives:
  - state=IDLE, mole_en=0, sec_left=0, score=0, game_over=0.
  - Sub-tick counter=0, mole timer=0, LFSR=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle in every state.
  - Candidate index = lfsr[log2(NUM_MOLES)-1:0].
  - If the candidate equals the previous mole index, use (candidate+1) mod NUM_MOLES.
- IDLE:
  - start → COUNT, with sec_left=COUNTDOWN_SEC and sub-tick=0.
- COUNT:
  - Each tick increments sub-tick.
  - When sub-tick is TICKS_PER_SEC-1, a tick wraps it to 0 and decrements sec_left.
  - A wrap while sec_left==1 → PLAY. On entry: sec_left=ROUND_SEC, score=0, a mole is raised, mole timer=MOLE_UP_TICKS.
  - sec_left never shows 0 in COUNT.
- PLAY:
  - Seconds count down exactly as in COUNT.
  - A wrap while sec_left==1 → DONE with sec_left=0.
  - Hit: a hit_btn bit that matches the raised mole.
    - score increments, saturating at 2^SCORE_W-1.
    - mole_en clears.
  - Expiry: mole timer decrements on each tick; on reaching 0, mole_en clears.
  - While mole_en==0 in PLAY, the next tick raises a new mole and reloads the timer. This gives a gap of at least one tick.
  - Non-matching button bits, or any button while no mole is raised, have no effect (see Configuration).
- DONE:
  - game_over=1, mole_en=0; score and sec_left=0 hold.
  - start → COUNT, same as from IDLE.
- start is ignored in COUNT and PLAY.

## Timing
- Latency from an accepted start edge to the state/sec_left change: 1 cycle.
- Latency from a hit_btn edge to the score update and mole_en clear: 1 cycle.
- Hit and mole expiry in the same cycle: the hit wins; score increments and mole_en clears.
- Hit and final-second wrap in the same cycle: the hit is scored, then → DONE; the final score includes the hit.
- Multiple hit_btn bits in one cycle: only the matching bit counts, at most +1 per cycle.
- tick and start in the same cycle in IDLE/DONE: start is taken; that tick is not counted.
- Reset asserted mid-round → IDLE on that edge; no partial score is retained.
- Nominal 5 s countdown: 5×TICKS_PER_SEC ticks from start to PLAY. A 30 s round equals 30×TICKS_PER_SEC ticks.

## Configuration
- MISS_PENALTY_EN:
  - Defined: in PLAY, a cycle with any hit_btn bit set and no matching hit decrements score by 1, saturating at 0. This includes presses while no mole is raised.
  - Undefined: misses are ignored and score only increases.
  - A cycle containing a matching hit never applies the penalty.

## Test plan
- Reset, then start with TICKS_PER_SEC=4 → sec_left reads 5,4,3,2,1 with 4 ticks each. On the 20th tick: state=PLAY, sec_left=30, exactly one mole_en bit set, score=0.
- In PLAY, press the matching hit_btn → score=1 and mole_en=0 on the next cycle. The next tick raises a different index.
- Never press → each mole clears after 4 ticks. After 120 ticks: state=DONE, game_over=1, score=0, mole_en=0.
- In PLAY with score=3, press a wrong button → score stays 3 without the macro; with MISS_PENALTY_EN, score=2. With score=0 and the macro, score stays 0.
- Hit on the same cycle as mole expiry → score+1; hit on the final-second wrap → DONE with the hit counted.
- Assert reset mid-PLAY with score=7 → next cycle: state=IDLE, score=0, mole_en=0, sec_left=0. start during PLAY is ignored.
